fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the RV32I pipeline, sitting between instruction memory and decode. It issues sequential word fetches, tolerates variable memory latency with several requests outstanding, and buffers returned instructions in a DEPTH-entry FIFO with their PCs. It supports PC redirect (branch/jump) with flush and discard of stale responses, and flags instructions whose opcode is outside the base set.

Parameters:
XLEN, 32, PC/address width (32 or 64)
DEPTH, 4, instruction FIFO entries; power of 2, >=2
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..DEPTH
RESET_PC, 0, fetch PC after reset; 4-byte aligned

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  load new fetch PC and flush
redirect_pc  in  XLEN  new PC; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid; in order, one per accepted request, no backpressure
imem_rsp_data  in  32  instruction word
dec_valid  out  1  FIFO head valid
dec_ready  in  1  decode consumes head
dec_instr  out  32  head instruction
dec_pc  out  XLEN  head PC
dec_illegal  out  1  head opcode not in base set
occupancy  out  $clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; all outputs 0 except imem_req_addr=RESET_PC.
- Credit rule: imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING && (occupancy+outstanding)<DEPTH. This guarantees a FIFO slot for every response, so no overflow is possible.
- imem_req_addr=fetch_pc. On valid&&ready: fetch_pc+=4 (wraps modulo 2^XLEN), outstanding++.
- Requests must not be withdrawn except by redirect, which deasserts imem_req_valid combinationally in its cycle.
- Response while drop==0: enqueue {imem_rsp_data, rsp_pc}; rsp_pc+=4; outstanding--.
- Response while drop>0: discard; drop--; outstanding--.
- Counters: outstanding and drop are $clog2(MAX_OUTSTANDING+1) bits; same-cycle accept and response leaves outstanding unchanged.
- FIFO: registered circular buffer; rd/wr pointers wrap at DEPTH. A response in cycle N appears on dec_valid in cycle N+1; there is no combinational bypass.
- Decode handshake: pop on dec_valid&&dec_ready. dec_valid/dec_instr/dec_pc depend only on registered state. Push and pop in the same cycle keeps occupancy constant, including when full.
- Redirect, cycle N: a decode pop in N completes normally. At edge N+1: FIFO cleared; fetch_pc=rsp_pc={redirect_pc[XLEN-1:2],2'b00}; drop = outstanding minus any response arriving in N that was itself consumed (discarded or enqueued-then-flushed), plus any request accepted in N (always 0). A response in cycle N is neither enqueued nor counted into drop. dec_valid=0 in N+1. First post-redirect request is presented in N+1.
- Back-to-back redirects: each reloads the PC. drop accumulates correctly because it always equals the outstanding count after the flush.
- dec_illegal = dec_valid && (instr[1:0]!=2'b11 || instr[6:0] not in {0000011, 0001111, 0010011, 0010111, 0110011, 0110111, 0100011, 1100011, 1100111, 1101111, 1110011}). Combinational from head; it does not stall the queue.
- Invariants (assert in bench): occupancy+outstanding<=DEPTH; drop<=outstanding; no response with outstanding==0.

Test Plan:
1. Reset, memory ready, 1-cycle latency, dec_ready=1 -> addresses 0x0, 0x4, 0x8... issued; dec_pc 0x0 appears with dec_valid two cycles after first request acceptance; one instruction per cycle sustained.
2. DEPTH=4, dec_ready=0, memory always ready -> exactly 4 requests accepted, occupancy=4, imem_req_valid=0. Raise dec_ready for one cycle -> one pop, then exactly one new request.
3. MAX_OUTSTANDING=2, 5-cycle latency -> never more than 2 accepted without response; outstanding counter peaks at 2.
4. Two requests outstanding (0x10, 0x14); redirect_pc=0x103 -> fetch resumes at 0x100; both stale responses discarded; first dec_pc after flush is 0x100.
5. Redirect in the same cycle as a response and a decode pop -> pop completes, response dropped, drop==outstanding-1, no stale instruction ever reaches decode.
6. Head words 0x00000013 (ADDI), 0x0000007F, 0x00000012 -> dec_illegal = 0, 1, 1. Assert rst_n low mid-stream -> outputs clear immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bus bundle for the instruction-fetch front end.
// It carries the redirect input, the imem request/response channels and the decode channel.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     redirect_valid;
  logic [XLEN-1:0]          redirect_pc;
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [XLEN-1:0]          imem_req_addr;
  logic                     imem_rsp_valid;
  logic [31:0]              imem_rsp_data;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [31:0]              dec_instr;
  logic [XLEN-1:0]          dec_pc;
  logic                     dec_illegal;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_illegal, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_illegal, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with credit-limited outstanding requests, a PC-tagged
// instruction FIFO, and redirect/flush that discards responses to stale requests.
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [OW-1:0]   outstanding_reg, outstanding_next;
  logic [OW-1:0]   drop_reg, drop_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic [CW:0]     inflight;
  logic [XLEN-1:0] redirect_aligned;
  logic            req_valid, accept, rsp, enq, pop, head_valid;

  function automatic logic is_base_opcode(input logic [6:0] op);
    logic hit;
    case (op)
      7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0110011, 7'b0110111,
      7'b0100011, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011: hit = 1'b1;
      default:                                                    hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Every accepted request owns a FIFO slot, so responses can never overflow the buffer.
  assign inflight         = {1'b0, count_reg} + (CW+1)'(outstanding_reg);
  assign req_valid        = rst_n && !bus.redirect_valid
                            && (outstanding_reg < OW'(MAX_OUTSTANDING))
                            && (inflight < (CW+1)'(DEPTH));
  assign accept           = req_valid && bus.imem_req_ready;
  assign rsp              = bus.imem_rsp_valid;
  assign enq              = rsp && (drop_reg == '0) && !bus.redirect_valid;
  assign head_valid       = (count_reg != '0);
  assign pop              = head_valid && bus.dec_ready;
  assign redirect_aligned = bus.redirect_pc & ~XLEN'(3);

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    outstanding_next = outstanding_reg + OW'(accept) - OW'(rsp);
    drop_next        = drop_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    count_next       = count_reg;
    if (accept) fetch_pc_next = fetch_pc_reg + XLEN'(4);
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old stream.
      fetch_pc_next = redirect_aligned;
      rsp_pc_next   = redirect_aligned;
      drop_next     = outstanding_reg - OW'(rsp);
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (rsp && (drop_reg != '0)) drop_next = drop_reg - OW'(1);
      if (enq) begin
        rsp_pc_next = rsp_pc_reg + XLEN'(4);
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = enq && (wr_ptr_reg == PW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        instr_mem[i] <= bus.imem_rsp_data;
        pc_mem[i]    <= rsp_pc_reg;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_reg;
  assign bus.dec_valid      = head_valid;
  assign bus.dec_instr      = head_valid ? instr_mem[rd_ptr_reg] : '0;
  assign bus.dec_pc         = head_valid ? pc_mem[rd_ptr_reg] : '0;
  assign bus.dec_illegal    = head_valid && ((instr_mem[rd_ptr_reg][1:0] != 2'b11)
                              || !is_base_opcode(instr_mem[rd_ptr_reg][6:0]));
  assign bus.occupancy      = count_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: an in-order memory with variable latency plus an
// epoch-tagged reference model of what decode should see, cycle by cycle.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [6:0]  LEGAL [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h33, 7'h37,
                                         7'h23, 7'h63, 7'h67, 7'h6F, 7'h73};

  logic clk;
  logic rst_n;
  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t        pending [$];
  ent_t        fifo_m  [$];
  int          tests = 0, fails = 0;
  int          cyc = 0, epoch = 0, peak = 0, acc_cnt = 0, watch = 0;
  int          ill_val [3];
  logic [31:0] m_fetch_pc;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a[5:2])
      4'd0:  w = 32'h00000013;  4'd1:  w = 32'h0000007F;
      4'd2:  w = 32'h00000012;  4'd3:  w = 32'h00A00093;
      4'd4:  w = 32'h00000037;  4'd5:  w = 32'h0000006F;
      4'd6:  w = 32'h00000063;  4'd7:  w = 32'h00000073;
      4'd8:  w = 32'h00000003;  4'd9:  w = 32'h00000023;
      4'd10: w = 32'h00000033;  4'd11: w = 32'h0000000B;
      4'd12: w = 32'h00000017;  4'd13: w = 32'h00000067;
      4'd14: w = 32'h0000000F;  default: w = 32'h00000077;
    endcase
    return w ^ {a[24:0], 7'b0};
  endfunction

  function automatic logic model_illegal(input logic [31:0] w);
    logic found = 1'b0;
    foreach (LEGAL[i]) if (w[6:0] == LEGAL[i]) found = 1'b1;
    return !(w[1:0] == 2'b11 && found);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0;  bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;    bus.dec_ready = 1'b0;
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_req_addr",  64'(bus.imem_req_addr),  64'(RPC));
    chk("rst_dec_valid", 64'(bus.dec_valid),      64'd0);
    chk("rst_dec_instr", 64'(bus.dec_instr),      64'd0);
    chk("rst_dec_pc",    64'(bus.dec_pc),         64'd0);
    chk("rst_illegal",   64'(bus.dec_illegal),    64'd0);
    chk("rst_occupancy", 64'(bus.occupancy),      64'd0);
    pending.delete();
    fifo_m.delete();
    epoch++;
    m_fetch_pc = RPC;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input int redir_p, input int ready_p, input int dec_p,
                      input int lat_min, input int lat_max,
                      input logic [31:0] rpc, input bit rpc_rand);
    logic rsp_v, accept, exp_valid;
    req_t r;
    @(negedge clk);
    bus.redirect_valid = ($urandom_range(99) < redir_p);
    bus.redirect_pc    = rpc_rand ? $urandom : rpc;
    bus.imem_req_ready = ($urandom_range(99) < ready_p);
    bus.dec_ready      = ($urandom_range(99) < dec_p);
    rsp_v = (pending.size() > 0) && (pending[0].due <= cyc);
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_v ? mem_word(pending[0].addr) : 32'h0;
    #1;
    exp_valid = !bus.redirect_valid && (pending.size() < MAXO)
                && (fifo_m.size() + pending.size() < DEPTH);
    chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_valid));
    chk("req_addr",  64'(bus.imem_req_addr),  64'(m_fetch_pc));
    chk("dec_valid", 64'(bus.dec_valid),      64'(fifo_m.size() != 0));
    chk("occupancy", 64'(bus.occupancy),      64'(fifo_m.size()));
    chk("inv_credit", 64'(int'(bus.occupancy) + pending.size() <= DEPTH), 64'd1);
    if (fifo_m.size() != 0) begin
      chk("dec_instr",   64'(bus.dec_instr),   64'(fifo_m[0].instr));
      chk("dec_pc",      64'(bus.dec_pc),      64'(fifo_m[0].pc));
      chk("dec_illegal", 64'(bus.dec_illegal), 64'(model_illegal(fifo_m[0].instr)));
    end else begin
      chk("dec_illegal_idle", 64'(bus.dec_illegal), 64'd0);
    end
    if (bus.dec_valid && bus.dec_pc < 32'd12) ill_val[bus.dec_pc[3:2]] = int'(bus.dec_illegal);
    if (watch != 0 && bus.dec_valid) begin
      first_pc = bus.dec_pc;
      watch    = 0;
    end

    accept = bus.imem_req_valid && bus.imem_req_ready;
    if (bus.dec_ready && fifo_m.size() != 0) void'(fifo_m.pop_front());
    if (rsp_v) begin
      r = pending.pop_front();
      if (r.epoch == epoch && !bus.redirect_valid)
        fifo_m.push_back('{instr: mem_word(r.addr), pc: r.addr});
    end
    if (accept) begin
      pending.push_back('{addr: bus.imem_req_addr, epoch: epoch,
                          due: cyc + int'($urandom_range(lat_max, lat_min))});
      m_fetch_pc = m_fetch_pc + 32'd4;
      acc_cnt++;
    end
    if (bus.redirect_valid) begin
      fifo_m.delete();
      epoch++;
      m_fetch_pc = bus.redirect_pc & ~32'd3;
    end
    if (pending.size() > peak) peak = pending.size();
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    ill_val = '{-1, -1, -1};
    m_fetch_pc = RPC;

    // Streaming from reset: one request and one instruction per cycle.
    do_reset();
    acc_cnt = 0;
    repeat (12) step(0, 100, 100, 1, 1, 32'h0, 1'b0);
    chk("sustained_accepts", 64'(acc_cnt), 64'd12);
    chk("illegal_addi", 64'(ill_val[0]), 64'd0);
    chk("illegal_7f",   64'(ill_val[1]), 64'd1);
    chk("illegal_12",   64'(ill_val[2]), 64'd1);

    // Decode stalled: FIFO fills to DEPTH and requests stop.
    repeat (8) step(0, 100, 0, 1, 1, 32'h0, 1'b0);
    chk("full_occupancy", 64'(bus.occupancy),      64'(DEPTH));
    chk("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
    step(0, 100, 100, 1, 1, 32'h0, 1'b0);
    acc_cnt = 0;
    repeat (6) step(0, 100, 0, 1, 1, 32'h0, 1'b0);
    chk("one_refill", 64'(acc_cnt), 64'd1);

    // Long latency: outstanding count is capped.
    repeat (6) step(0, 100, 100, 1, 1, 32'h0, 1'b0);
    peak = 0;
    repeat (30) step(0, 100, 100, 5, 5, 32'h0, 1'b0);
    chk("outstanding_peak", 64'(peak), 64'(MAXO));

    // Redirect with two requests in flight; stale responses must be discarded.
    do_reset();
    repeat (2) step(0, 100, 100, 5, 5, 32'h0, 1'b0);
    chk("pre_redirect_pending", 64'(pending.size()), 64'd2);
    step(100, 100, 100, 5, 5, 32'h103, 1'b0);
    watch = 1;
    first_pc = '0;
    repeat (15) step(0, 100, 100, 5, 5, 32'h0, 1'b0);
    chk("first_pc_after_redirect", 64'(first_pc), 64'h100);

    // Random traffic with frequent redirects, then an asynchronous reset mid-stream.
    repeat (600) step(12, 70, 60, 1, 4, 32'h0, 1'b1);
    do_reset();
    repeat (10) step(0, 100, 100, 1, 2, 32'h0, 1'b0);
    repeat (300) step(8, 80, 50, 1, 5, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
